// File: rtl/game_pkg.sv
// Shared playfield geometry, LFSR constants, FSM state codes and small helpers
// used by the reflex-game target path.
package game_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int HUD_H  = 64;
  localparam int RADIUS = 16;

  localparam logic [15:0] LFSR_MASK    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  localparam logic [9:0] FALLBACK_X = 10'(H_RES / 2);
  localparam logic [9:0] FALLBACK_Y = 10'(V_RES / 2);

  localparam logic [6:0] SCORE_MAX = 7'd99;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GEN    = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  // Galois step for x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
  endfunction

  function automatic logic [10:0] abs_diff(input logic [9:0] a, input logic [9:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

  function automatic logic [6:0] sat_inc(input logic [6:0] c);
    return (c >= SCORE_MAX) ? c : c + 7'd1;
  endfunction

endpackage

// File: rtl/target_spawner_if.sv
// Control inputs and target outputs between the game controller and the spawner.
interface target_spawner_if;
  logic       start;
  logic       jump_start;
  logic       hit;
  logic [9:0] ballX;
  logic [9:0] ballY;
  logic       ball_valid;
  logic       miss;
  logic [6:0] spawn_count;
  logic [6:0] miss_count;

  modport master (
    output start, jump_start, hit,
    input  ballX, ballY, ball_valid, miss, spawn_count, miss_count
  );

  modport slave (
    input  start, jump_start, hit,
    output ballX, ballY, ball_valid, miss, spawn_count, miss_count
  );
endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR; loads the seed on reset and steps every cycle.
module lfsr16
  import game_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;

  // NOTE: state updates use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) r_q <= seed;
    else      r_q <= lfsr_next(r_q);
  end

  assign q = r_q;

endmodule

// File: rtl/target_spawner.sv
// Places targets by rejection sampling LFSR candidates, then times them out or
// re-spawns on a hit while keeping saturating spawn/miss counts.
module target_spawner
  import game_pkg::*;
#(
  parameter int          CLK_HZ      = 100_000_000,
  parameter int          LIFETIME_MS = 1500,
  parameter int          MAX_TRIES   = 64,
  parameter logic [15:0] SEED        = DEFAULT_SEED
) (
  input logic             clk,
  input logic             rst,
  target_spawner_if.slave bus
);

  localparam int PRESCALE = CLK_HZ / 1000;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int LW = (LIFETIME_MS > 1) ? $clog2(LIFETIME_MS) : 1;
  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
  localparam logic [LW-1:0] LIFE_LAST = LW'(LIFETIME_MS - 1);
  localparam logic [TW-1:0] TRY_LAST  = TW'(MAX_TRIES - 1);

  localparam logic [10:0] X_MIN   = 11'(RADIUS);
  localparam logic [10:0] X_MAX   = 11'(H_RES - 1 - RADIUS);
  localparam logic [10:0] Y_MIN   = 11'(HUD_H + RADIUS);
  localparam logic [10:0] Y_MAX   = 11'(V_RES - 1 - RADIUS);
  localparam logic [10:0] MIN_SEP = 11'(2 * RADIUS);

  logic [15:0]   w_lfsr;
  logic [9:0]    w_cand_x;
  logic [9:0]    w_cand_y;
  logic [10:0]   w_dx;
  logic [10:0]   w_dy;
  logic          w_in_bounds;
  logic          w_overlap;
  logic          w_accept;
  logic          w_tick;

  logic [1:0]    r_state;
  logic [9:0]    r_ball_x;
  logic [9:0]    r_ball_y;
  logic          r_miss;
  logic [6:0]    r_spawn_cnt;
  logic [6:0]    r_miss_cnt;
  logic [TW-1:0] r_tries;
  logic [PW-1:0] r_pre;
  logic [LW-1:0] r_life;

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (w_lfsr)
  );

  // Overlapping bit fields give two loosely correlated coordinates per step.
  assign w_cand_x = w_lfsr[9:0];
  assign w_cand_y = w_lfsr[15:6];
  assign w_dx     = abs_diff(w_cand_x, r_ball_x);
  assign w_dy     = abs_diff(w_cand_y, r_ball_y);

  assign w_in_bounds = ({1'b0, w_cand_x} >= X_MIN) && ({1'b0, w_cand_x} <= X_MAX) &&
                       ({1'b0, w_cand_y} >= Y_MIN) && ({1'b0, w_cand_y} <= Y_MAX);
  assign w_overlap   = (w_dx < MIN_SEP) && (w_dy < MIN_SEP);
  assign w_accept    = w_in_bounds && !w_overlap;
  assign w_tick      = (r_pre == PRE_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_ball_x    <= FALLBACK_X;
      r_ball_y    <= FALLBACK_Y;
      r_miss      <= 1'b0;
      r_spawn_cnt <= '0;
      r_miss_cnt  <= '0;
      r_tries     <= '0;
      r_pre       <= '0;
      r_life      <= '0;
    end else begin
      r_miss <= 1'b0;
      // A new game overrides everything, including a low start this cycle.
      if (bus.jump_start) begin
        r_state     <= ST_GEN;
        r_spawn_cnt <= '0;
        r_miss_cnt  <= '0;
        r_tries     <= '0;
      end else if (!bus.start) begin
        r_state <= ST_IDLE;
      end else begin
        case (r_state)
          ST_GEN: begin
            if (w_accept || (r_tries == TRY_LAST)) begin
              r_ball_x    <= w_accept ? w_cand_x : FALLBACK_X;
              r_ball_y    <= w_accept ? w_cand_y : FALLBACK_Y;
              r_tries     <= '0;
              r_spawn_cnt <= sat_inc(r_spawn_cnt);
              r_pre       <= '0;
              r_life      <= '0;
              r_state     <= ST_ACTIVE;
            end else begin
              r_tries <= r_tries + 1'b1;
            end
          end
          ST_ACTIVE: begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (bus.hit) begin
              r_state <= ST_GEN;
            end else if (w_tick) begin
              if (r_life == LIFE_LAST) begin
                r_miss     <= 1'b1;
                r_miss_cnt <= sat_inc(r_miss_cnt);
                r_state    <= ST_GEN;
              end else begin
                r_life <= r_life + 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.ballX       = r_ball_x;
  assign bus.ballY       = r_ball_y;
  assign bus.ball_valid  = (r_state == ST_ACTIVE);
  assign bus.miss        = r_miss;
  assign bus.spawn_count = r_spawn_cnt;
  assign bus.miss_count  = r_miss_cnt;

endmodule

// File: doc/target_spawner.md
Name: target_spawner

Overview:
Generates the on-screen target position for the reflex game; sits directly upstream of the score keeper, target renderer and mouse hit checker. It uses a free-running 16-bit LFSR and rejection sampling to place targets inside the playfield, clear of the HUD band and the previous target. On a hit or a lifetime timeout it re-spawns the target and counts spawns and misses.

Parameters:
CLK_HZ, 100000000, system clock frequency; used to derive the 1 ms tick.
H_RES, 640, playfield width in pixels.
V_RES, 480, playfield height in pixels.
RADIUS, 16, target radius in pixels.
HUD_H, 64, height of the top band reserved for time/score; no target may overlap it.
LIFETIME_MS, 1500, time an unhit target stays up before it counts as a miss.
MAX_TRIES, 64, rejection attempts allowed before the fallback position is used.
SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  synchronous reset, active-low
start  in  1  level; game running
jump_start  in  1  one-cycle pulse; new game begins
hit  in  1  one-cycle pulse from the hit checker (new_ball)
ballX  out  10  target centre X
ballY  out  10  target centre Y
ball_valid  out  1  target is live and may be drawn or hit
miss  out  1  one-cycle pulse when a target expires
spawn_count  out  7  targets spawned this game; saturates at 99
miss_count  out  7  targets expired this game; saturates at 99

Behaviour:
- Reset (rst==0 at a clk edge): ballX=H_RES/2 (320), ballY=V_RES/2 (240), ball_valid=0, miss=0, both counts=0, LFSR=SEED, state=IDLE, lifetime and prescaler counters=0.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Steps every cycle in every state. Candidate X=lfsr[9:0], candidate Y=lfsr[15:6].
- Accept a candidate only when all of these hold:
  - RADIUS <= X <= H_RES-1-RADIUS.
  - HUD_H+RADIUS <= Y <= V_RES-1-RADIUS.
  - NOT (|X-ballX| < 2*RADIUS AND |Y-ballY| < 2*RADIUS), i.e. no overlap with the previous target.
  - Use 11-bit unsigned differences (larger minus smaller); no wrap.
- States:
  - IDLE: ball_valid=0. jump_start -> GEN, clear both counts, tries=0. start==0 keeps the block here.
  - GEN: one candidate tested per cycle.
    - Accept: register X/Y, tries=0, spawn_count+=1 (saturating), clear the lifetime counter, go to ACTIVE.
    - Reject: tries+=1.
    - tries==MAX_TRIES-1 and reject: load the fallback (320,240) and treat it as accepted.
  - ACTIVE: ball_valid=1.
    - A 1 ms tick comes from a prescaler counting 0..CLK_HZ/1000-1; each tick increments the lifetime counter.
    - hit -> GEN (ball_valid=0 next cycle).
    - Lifetime reaches LIFETIME_MS -> miss pulse for one cycle, miss_count+=1 (saturating), -> GEN.
- Latency: hit at edge n -> ball_valid=0 after edge n+1. First-try accept -> new position and ball_valid=1 after edge n+2. Worst case is MAX_TRIES+1 cycles.
- ballX/ballY change only on accept or fallback; they hold during GEN and IDLE.
- Simultaneous events and corner cases:
  - hit and timeout in the same cycle: hit wins, no miss, miss_count unchanged.
  - hit in IDLE or GEN: ignored.
  - start falling in any state: -> IDLE next cycle, ball_valid=0, counts held, no miss.
  - jump_start in any state: restarts (-> GEN, counts cleared); it overrides hit and timeout.
  - jump_start with start==0: still enters GEN; the start==0 check applies from the next cycle.
- Counts saturate at 99 (max for the seven-segment display); no wrap.
- Reset mid-operation: all state returns to reset values at that edge, regardless of state.

Decomposition:
- Shared package game_pkg: H_RES, V_RES, HUD_H, RADIUS, LFSR mask 16'hB400, default SEED, fallback coordinates, state enum (IDLE/GEN/ACTIVE), score saturation limit 99.
- One sub-module lfsr16 (clk, rst, seed, q[15:0]) holding the free-running Galois LFSR. Acceptance logic, FSM and counters stay in target_spawner.

Test Plan:
1. Reset, then jump_start with start=1 -> ball_valid=1 within 65 cycles; spawn_count=1; 16<=ballX<=623; 80<=ballY<=463; miss_count=0.
2. 200 hits, each issued 3 cycles after ball_valid -> every position inside the bounds; no consecutive pair within 32 px on both axes; spawn_count saturates at 99.
3. CLK_HZ=10000, LIFETIME_MS=2, no hits -> miss pulses exactly 1 cycle, 20 cycles after each ball_valid rise; miss_count increments by 1 each time.
4. hit and timeout asserted together -> no miss pulse, miss_count unchanged, spawn_count+1.
5. MAX_TRIES=1, SEED chosen so the first candidate is out of bounds -> ballX=320, ballY=240 after 2 cycles.
6. start dropped while ACTIVE -> ball_valid=0 next cycle, counts held. Then rst=0 mid-GEN -> all outputs at their reset values.
